dftn_stream: RTL and testbench

DFTN_STREAM -- requirements
Module: dftn_stream

---
 rtl/dftn_stream.sv | 208 ++++++++++++++++++++
 tb/tb_dftn_stream.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dftn_stream.sv
// Streaming N-point DFT: loads N samples in LANES-wide beats, then produces one bin at a time
// using LANES parallel multipliers. Define DFTN_SAT_EN to clamp results to OW bits and drive ovf.
module dftn_stream #(
  parameter int N     = 64,
  parameter int LANES = 8,
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int OW    = 24
) (
  input  logic                  clk,
  input  logic                  sreset,
  input  logic                  calculate,
  input  logic                  rel,
  input  logic [LANES*DW-1:0]   samples,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(N)-1:0]  out_bin,
  output logic signed [OW-1:0]  out_real,
  output logic signed [OW-1:0]  out_imag,
  output logic                  done,
  output logic                  ovf
);

  localparam int LOG2N = $clog2(N);
  localparam int NB    = N / LANES;
  localparam int CW    = $clog2(NB);
  localparam int AW    = DW + TW + LOG2N;
  localparam int RW    = AW - (TW - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_OUT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [LOG2N-1:0]        k_q, k_d;
  logic signed [AW-1:0]    acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic                    load_en;
  logic signed [DW-1:0]    sbuf_q [N];

  // Twiddles rounded half away from zero; +1.0 does not fit Q1.(TW-1) and is clamped.
  function automatic logic signed [TW-1:0] twiddle(input int m, input bit want_sin);
    real    ang, v;
    longint r;
    ang = 6.283185307179586 * real'(m) / real'(N);
    v   = (want_sin ? $sin(ang) : $cos(ang)) * (2.0 ** (TW - 1));
    if (v >= 0.0) r = longint'($rtoi(v + 0.5));
    else          r = -longint'($rtoi(0.5 - v));
    if (r > (longint'(1) <<< (TW - 1)) - 1) r = (longint'(1) <<< (TW - 1)) - 1;
    return TW'(r);
  endfunction

  logic signed [TW-1:0] cos_rom [N];
  logic signed [TW-1:0] sin_rom [N];

  for (genvar g = 0; g < N; g++) begin : g_rom
    assign cos_rom[g] = twiddle(g, 1'b0);
    assign sin_rom[g] = twiddle(g, 1'b1);
  end

  // Sample index of lane 0 for the current beat / CALC cycle.
  logic [LOG2N-1:0] base;
  assign base = LOG2N'(cnt_q) * LOG2N'(LANES);

  logic [LOG2N-1:0]        nidx, midx;
  logic signed [DW+TW-1:0] p_re, p_im;
  logic signed [AW-1:0]    sum_re, sum_im;

  always_comb begin
    sum_re = '0;
    sum_im = '0;
    nidx   = '0;
    midx   = '0;
    p_re   = '0;
    p_im   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      nidx   = base + LOG2N'(i);
      midx   = k_q * nidx;
      p_re   = sbuf_q[nidx] * cos_rom[midx];
      p_im   = sbuf_q[nidx] * sin_rom[midx];
      sum_re = sum_re + AW'(p_re);
      sum_im = sum_im + AW'(p_im);
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        sbuf_q[base + LOG2N'(i)] <= samples[(LANES - i) * DW - 1 -: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    load_en   = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (calculate) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          k_d     = '0;
        end
      end
      S_LOAD: begin
        if (rel) begin
          load_en = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(NB - 1)) begin
            state_d  = S_CALC;
            acc_re_d = '0;
            acc_im_d = '0;
          end
        end
      end
      S_CALC: begin
        acc_re_d = acc_re_q + sum_re;
        acc_im_d = acc_im_q - sum_im;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(NB - 1)) state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (k_q == LOG2N'(N - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_CALC;
            k_d      = k_q + LOG2N'(1);
            acc_re_d = '0;
            acc_im_d = '0;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
    end
  end

  assign out_bin = k_q;

  logic signed [RW-1:0] r_re, r_im;
  assign r_re = RW'(acc_re_q >>> (TW - 1));
  assign r_im = RW'(acc_im_q >>> (TW - 1));

`ifdef DFTN_SAT_EN
  localparam int XW = RW + OW;
  localparam logic signed [XW-1:0] XMAX = {{(RW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [XW-1:0] XMIN = {{(RW + 1){1'b1}}, {(OW - 1){1'b0}}};
  localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW - 1){1'b1}}};
  localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW - 1){1'b0}}};

  logic signed [XW-1:0] x_re, x_im;
  logic                 clip_re, clip_im;
  logic                 ovf_q, ovf_d;

  assign x_re     = XW'(r_re);
  assign x_im     = XW'(r_im);
  assign clip_re  = (x_re > XMAX) || (x_re < XMIN);
  assign clip_im  = (x_im > XMAX) || (x_im < XMIN);
  assign out_real = clip_re ? (x_re[XW-1] ? OMIN : OMAX) : x_re[OW-1:0];
  assign out_imag = clip_im ? (x_im[XW-1] ? OMIN : OMAX) : x_im[OW-1:0];

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_IDLE && calculate)                  ovf_d = 1'b0;
    else if (state_q == S_OUT && (clip_re || clip_im))   ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign out_real = OW'(r_re);
  assign out_imag = OW'(r_im);
  assign ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_dftn_stream.sv
// Scoreboard bench for dftn_stream: a direct-DFT reference model fills an expected queue,
// a negedge monitor checks every presented bin plus latency and done timing.
module tb_dftn_stream;

  localparam int N      = 64;
  localparam int LANES  = 8;
  localparam int DW     = 16;
  localparam int TW     = 16;
  localparam int OW     = 24;
  localparam int OW2    = 20;
  localparam int NB     = N / LANES;
  localparam int LOG2N  = $clog2(N);
  localparam int BUDGET = N * (NB + 1) * 4 + 100;

  logic                  clk = 1'b0;
  logic                  sreset = 1'b1;
  logic                  calculate = 1'b0, rel = 1'b0, out_ready = 1'b1;
  logic [LANES*DW-1:0]   samples = '0;
  logic                  busy, out_valid, done, ovf;
  logic [LOG2N-1:0]      out_bin;
  logic [OW-1:0]         out_real, out_imag;

  logic                  calc2 = 1'b0, rel2 = 1'b0, rdy2 = 1'b1;
  logic [LANES*DW-1:0]   smp2 = '0;
  logic                  busy2, valid2, done2, ovf2;
  logic [LOG2N-1:0]      bin2;
  logic [OW2-1:0]        real2, imag2;

  dftn_stream #(.N(N), .LANES(LANES), .DW(DW), .TW(TW), .OW(OW)) dut (
    .clk(clk), .sreset(sreset), .calculate(calculate), .rel(rel), .samples(samples),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_real(out_real), .out_imag(out_imag), .done(done), .ovf(ovf));

  dftn_stream #(.N(N), .LANES(LANES), .DW(DW), .TW(TW), .OW(OW2)) dut20 (
    .clk(clk), .sreset(sreset), .calculate(calc2), .rel(rel2), .samples(smp2),
    .busy(busy2), .out_valid(valid2), .out_ready(rdy2), .out_bin(bin2),
    .out_real(real2), .out_imag(imag2), .done(done2), .ovf(ovf2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int bin; longint re; longint im; } exp_t;
  exp_t   sbq[$];
  exp_t   mon_e;
  int     errors = 0, checks = 0;
  int     ref_cyc = 0, done_exp = -1, done_cnt = 0;
  bit     mon_en = 1'b0, prev_valid = 1'b0;
  int     xin [N];
  longint cos_t [N], sin_t [N];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint tw_round(input real v);
    real    s;
    longint r;
    s = v * (2.0 ** (TW - 1));
    if (s >= 0.0) r = longint'($rtoi(s + 0.5));
    else          r = -longint'($rtoi(0.5 - s));
    if (r > (longint'(1) << (TW - 1)) - 1) r = (longint'(1) << (TW - 1)) - 1;
    return r;
  endfunction

  function automatic longint fitw(input longint r, input int w);
    longint lim, t;
    lim = longint'(1) << (w - 1);
`ifdef DFTN_SAT_EN
    if (r > lim - 1) return lim - 1;
    if (r < -lim)    return -lim;
    return r;
`else
    t = r & ((lim << 1) - 1);
    if (t >= lim) t = t - (lim << 1);
    return t;
`endif
  endfunction

  // Direct DFT of xin from the defining sum, floored by 2^(TW-1) and fitted to OW bits.
  task automatic push_model();
    exp_t   ep;
    longint re, im;
    int     m;
    for (int k = 0; k < N; k++) begin
      re = 0;
      im = 0;
      for (int n = 0; n < N; n++) begin
        m  = (k * n) % N;
        re = re + longint'(xin[n]) * cos_t[m];
        im = im - longint'(xin[n]) * sin_t[m];
      end
      ep.bin = k;
      ep.re  = fitw(re >>> (TW - 1), OW);
      ep.im  = fitw(im >>> (TW - 1), OW);
      sbq.push_back(ep);
    end
  endtask

  task automatic push_impulse();
    exp_t ep;
    for (int k = 0; k < N; k++) begin
      ep.bin = k;
      ep.re  = 999;
      ep.im  = 0;
      sbq.push_back(ep);
    end
  endtask

  function automatic logic [LANES*DW-1:0] pack_beat(input int b);
    logic [LANES*DW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[(LANES - 1 - i) * DW +: DW] = DW'(xin[b * LANES + i]);
    return v;
  endfunction

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_valid) chk("bin_latency", cyc - ref_cyc, NB + 1);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bin: bin %0d presented, nothing expected", out_bin);
        end else begin
          mon_e = sbq[0];
          if (out_ready) begin
            chk("bin_idx", out_bin, mon_e.bin);
            chk("bin_real", $signed(out_real), mon_e.re);
            chk("bin_imag", $signed(out_imag), mon_e.im);
            void'(sbq.pop_front());
            ref_cyc = cyc;
            if (mon_e.bin == N - 1) done_exp = cyc + 1;
          end else begin
            chk("hold_idx", out_bin, mon_e.bin);
            chk("hold_real", $signed(out_real), mon_e.re);
            chk("hold_imag", $signed(out_imag), mon_e.im);
          end
        end
      end
      if (done) begin
        chk("done_timing", cyc, done_exp);
        done_cnt++;
      end
      prev_valid = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input bit imp_const, input bit gaps);
    rel     = 1'b1;
    samples = {$urandom, $urandom, $urandom, $urandom};
    step();
    rel = 1'b0;
    chk("idle_ignores_rel", busy, 0);
    calculate = 1'b1;
    step();
    calculate = 1'b0;
    chk("load_busy", busy, 1);
    if (imp_const) push_impulse();
    else           push_model();
    for (int b = 0; b < NB; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          rel       = 1'b0;
          calculate = 1'($urandom_range(0, 1));
          step();
        end
      end
      rel       = 1'b1;
      calculate = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      samples   = pack_beat(b);
      ref_cyc   = cyc;
      step();
    end
    rel       = 1'b0;
    calculate = 1'b0;
  endtask

  task automatic drain(input int mode, input int bp_bin);
    int d0, hold, n;
    d0   = done_cnt;
    hold = 0;
    n    = 0;
    while (done_cnt == d0 && n < BUDGET) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (out_valid && int'(out_bin) == bp_bin && hold < 20) begin
            out_ready = 1'b0;
            hold++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      step();
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
    chk("idle_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("sb_drained", sbq.size(), 0);
    out_ready = 1'b1;
  endtask

  initial begin
    int n;
    for (int m = 0; m < N; m++) begin
      cos_t[m] = tw_round($cos(6.283185307179586 * real'(m) / real'(N)));
      sin_t[m] = tw_round($sin(6.283185307179586 * real'(m) / real'(N)));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_bin", out_bin, 0);
    chk("rst_real", $signed(out_real), 0);
    chk("rst_imag", $signed(out_imag), 0);
    sreset = 1'b0;
    mon_en = 1'b1;
    step();

    for (int i = 0; i < N; i++) xin[i] = (i == 0) ? 1000 : 0;
    start_frame(1'b1, 1'b0);
    drain(0, -1);

    for (int i = 0; i < N; i++) xin[i] = 256;
    start_frame(1'b0, 1'b0);
    drain(2, 5);

    repeat (2) begin
      for (int i = 0; i < N; i++) xin[i] = int'($urandom_range(0, 65535)) - 32768;
      start_frame(1'b0, 1'b1);
      drain(1, -1);
    end

    for (int i = 0; i < N; i++) xin[i] = (i == 0) ? 1000 : 0;
    start_frame(1'b1, 1'b0);
    out_ready = 1'b1;
    n = 0;
    while (!(busy && !out_valid && out_bin == LOG2N'(10)) && n < BUDGET) begin
      step();
      n++;
    end
    chk("reach_bin10_calc", (n < BUDGET) ? 1 : 0, 1);
    mon_en = 1'b0;
    sreset = 1'b1;
    #1;
    chk("midcalc_rst_busy", busy, 0);
    chk("midcalc_rst_valid", out_valid, 0);
    chk("midcalc_rst_bin", out_bin, 0);
    chk("midcalc_rst_real", $signed(out_real), 0);
    sbq.delete();
    repeat (2) step();
    sreset = 1'b0;
    mon_en = 1'b1;
    step();
    start_frame(1'b1, 1'b0);
    drain(0, -1);
    chk("main_ovf", ovf, 0);

    calc2 = 1'b1;
    step();
    calc2 = 1'b0;
    for (int b = 0; b < NB; b++) begin
      rel2 = 1'b1;
      smp2 = {LANES{16'sh7FFF}};
      step();
    end
    rel2 = 1'b0;
    n = 0;
    while (!valid2 && n < BUDGET) begin
      step();
      n++;
    end
    chk("ovf_bin0_idx", bin2, 0);
`ifdef DFTN_SAT_EN
    chk("ovf_bin0_real", $signed(real2), 524287);
`else
    chk("ovf_bin0_real", $signed(real2), -128);
`endif
    chk("ovf_bin0_imag", $signed(imag2), 0);
    n = 0;
    while (!done2 && n < BUDGET) begin
      step();
      n++;
    end
    step();
`ifdef DFTN_SAT_EN
    chk("ovf_flag", ovf2, 1);
`else
    chk("ovf_flag", ovf2, 0);
`endif
    calc2 = 1'b1;
    step();
    calc2 = 1'b0;
    chk("ovf_cleared_on_load", ovf2, 0);
    for (int b = 0; b < NB; b++) begin
      rel2 = 1'b1;
      smp2 = '0;
      step();
    end
    rel2 = 1'b0;
    n = 0;
    while (!done2 && n < BUDGET) begin
      step();
      n++;
    end
    step();
    chk("ovf_dut_idle", busy2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
